// File: rtl/sequence_generator_moore.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated back-to-back, flagging each repetition start.
// Outputs are decoded only from the state and internal registers, so no input reaches an output combinationally.
module sequence_generator_moore #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [CNT_W-1:0]   repeat_cnt,
  input  logic               abort,
  output logic               out,
  output logic               valid,
  output logic               frame,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] shift_q, shift_d;
  logic [MAX_LEN-1:0] shadow_q, shadow_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d;

  logic               start_ok;
  logic [LEN_W-1:0]   align_amt;
  logic [MAX_LEN-1:0] pattern_aligned;

  // Left-align the active field so the next bit to send is always shift_q[MSB].
  assign align_amt       = LEN_W'(MAX_LEN) - length;
  assign pattern_aligned = pattern << align_amt;
  assign start_ok        = start && (length >= LEN_W'(1)) &&
                           (length <= LEN_W'(MAX_LEN)) && (repeat_cnt != '0);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    shadow_d  = shadow_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d   = ST_SHIFT;
          shift_d   = pattern_aligned;
          shadow_d  = pattern_aligned;
          len_d     = length;
          bit_cnt_d = length;
          rep_cnt_d = repeat_cnt;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          shift_d   = '0;
          bit_cnt_d = '0;
          rep_cnt_d = '0;
        end else if (bit_cnt_q > LEN_W'(1)) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
        end else if (rep_cnt_q > CNT_W'(1)) begin
          shift_d   = shadow_q;
          bit_cnt_d = len_q;
          rep_cnt_d = rep_cnt_q - CNT_W'(1);
        end else begin
          state_d   = ST_DONE;
          shift_d   = '0;
          bit_cnt_d = '0;
          rep_cnt_d = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      shadow_q  <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign busy  = (state_q == ST_SHIFT);
  assign valid = busy;
  assign out   = busy && shift_q[MAX_LEN-1];
  assign frame = busy && (bit_cnt_q == len_q);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_sequence_generator_moore.sv
// Directed bench for sequence_generator_moore: hand-computed streams, frame/done timing, illegal starts, abort, reset.
module tb_sequence_generator_moore;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic [7:0]  repeat_cnt;
  logic        abort;
  logic        out, valid, frame, busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int det_hits;
  logic [2:0] det_hist;

  sequence_generator_moore dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .length     (length),
    .repeat_cnt (repeat_cnt),
    .abort      (abort),
    .out        (out),
    .valid      (valid),
    .frame      (frame),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns in cycle T+1.
  task automatic send(input logic [15:0] p, input logic [4:0] l, input logic [7:0] r);
    pattern    = p;
    length     = l;
    repeat_cnt = r;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    pattern    = 16'h0;
    length     = 5'd0;
    repeat_cnt = 8'd0;
  endtask

  // Check nbits of exp (MSB first) with frame every l bits, then the done cycle and return to idle.
  task automatic expect_stream(input string tag, input logic [31:0] exp, input int nbits, input int l);
    det_hits = 0;
    det_hist = 3'b000;
    for (int k = 0; k < nbits; k++) begin
      check({tag, "_out"}, {31'd0, out}, {31'd0, exp[nbits-1-k]});
      check({tag, "_vld_busy"}, {30'd0, valid, busy}, 32'd3);
      check({tag, "_frame"}, {31'd0, frame}, {31'd0, (k % l) == 0});
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      det_hist = {det_hist[1:0], out};
      if (k >= 2 && det_hist == 3'b111) det_hits++;
      tick();
    end
    check({tag, "_done"}, {27'd0, out, valid, frame, busy, done}, 32'h01);
    tick();
    check({tag, "_idle"}, {27'd0, out, valid, frame, busy, done}, 32'h00);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = 16'h0; length = 5'd0; repeat_cnt = 8'd0;
    tick();
    tick();
    check("reset_outputs", {27'd0, out, valid, frame, busy, done}, 32'h00);
    reset = 1'b0;
    tick();
    check("post_reset_idle", {27'd0, out, valid, frame, busy, done}, 32'h00);

    // 111, one repetition: bits T+1..T+3, done at T+4
    send(16'h0007, 5'd3, 8'd1);
    expect_stream("p111", 32'b111, 3, 3);
    check("p111_detect", det_hits, 1);

    // 1011 twice: 10111011, frames at T+1/T+5, done at T+9; one overlapping 111 hit
    send(16'h000B, 5'd4, 8'd2);
    expect_stream("p1011x2", 32'b10111011, 8, 4);
    check("p1011x2_detect", det_hits, 1);

    // full width
    send(16'hA5C3, 5'd16, 8'd1);
    expect_stream("pA5C3", 32'h0000A5C3, 16, 16);

    // upper pattern bits beyond length must be ignored: 110 from 0xFFF6, three reps
    send(16'hFFF6, 5'd3, 8'd3);
    expect_stream("p110x3", 32'b110110110, 9, 3);

    // illegal starts
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: send(16'h00FF, 5'd0, 8'd1);
        1: send(16'h00FF, 5'd17, 8'd1);
        default: send(16'h00FF, 5'd4, 8'd0);
      endcase
      for (int c = 0; c < 20; c++) begin
        check("illegal_quiet", {29'd0, busy, valid, done}, 32'd0);
        tick();
      end
    end

    // abort: 8'hB6 = 10110110, restart attempt at T+2, abort at end of T+5
    send(16'h00B6, 5'd8, 8'd3);
    check("abort_b0", {31'd0, out}, 32'd1);
    tick();
    pattern = 16'h0000; length = 5'd2; repeat_cnt = 8'd1; start = 1'b1;
    check("abort_b1", {31'd0, out}, 32'd0);
    tick();
    start = 1'b0;
    check("abort_b2", {31'd0, out}, 32'd1);
    check("abort_b2_frame", {31'd0, frame}, 32'd0);
    tick();
    check("abort_b3", {31'd0, out}, 32'd1);
    tick();
    check("abort_b4", {31'd0, out}, 32'd0);
    check("abort_b4_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_T6_quiet", {27'd0, out, valid, frame, busy, done}, 32'h00);
    send(16'h0002, 5'd2, 8'd1);
    expect_stream("after_abort", 32'b10, 2, 2);

    // reset during SHIFT
    send(16'h000F, 5'd4, 8'd2);
    tick();
    tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_outputs", {27'd0, out, valid, frame, busy, done}, 32'h00);
    tick();
    check("mid_reset_stays", {27'd0, out, valid, frame, busy, done}, 32'h00);
    send(16'h0001, 5'd1, 8'd1);
    expect_stream("one_bit", 32'b1, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
